// File: rtl/sd_crc_16_chk_if.sv
// Serial DAT-line bundle between the line sampler (master) and the CRC-16 checker (slave).
// ABORT is present only when SD_CRC16_CHK_ABORT_EN is defined.
interface sd_crc_16_chk_if;
    logic        START;
    logic        BIT_EN;
    logic        BITVAL;
`ifdef SD_CRC16_CHK_ABORT_EN
    logic        ABORT;
`endif
    logic        BUSY;
    logic        DONE;
    logic        CRC_OK;
    logic [15:0] CRC_CALC;
    logic [15:0] CRC_RX;

    modport master (
`ifdef SD_CRC16_CHK_ABORT_EN
        output ABORT,
`endif
        output START, BIT_EN, BITVAL,
        input  BUSY, DONE, CRC_OK, CRC_CALC, CRC_RX
    );

    modport slave (
`ifdef SD_CRC16_CHK_ABORT_EN
        input  ABORT,
`endif
        input  START, BIT_EN, BITVAL,
        output BUSY, DONE, CRC_OK, CRC_CALC, CRC_RX
    );
endinterface

// File: rtl/sd_crc_16_chk.sv
// Bit-serial SD CRC-16 (x^16+x^12+x^5+1, init 0, MSB first) receive checker, one per DAT line.
// Define SD_CRC16_CHK_ABORT_EN to add the ABORT input that cancels a block in progress.
module sd_crc_16_chk #(
    parameter int BLOCK_BITS = 4096,
    parameter int CNT_W      = 13
) (
    input logic             CLK,
    input logic             RST,
    sd_crc_16_chk_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BLOCK_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(15);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_calc_q, crc_calc_d;
    logic [15:0]      crc_rx_q, crc_rx_d;
    logic             crc_ok_q, crc_ok_d;
    logic             done_q, done_d;

    logic             abort;
    logic             inv;
    logic [15:0]      lfsr_next;
    logic [15:0]      rx_shift;

`ifdef SD_CRC16_CHK_ABORT_EN
    assign abort = bus.ABORT;
`else
    assign abort = 1'b0;
`endif

    assign inv       = bus.BITVAL ^ crc_calc_q[15];
    assign lfsr_next = {crc_calc_q[14:12], crc_calc_q[11] ^ inv, crc_calc_q[10:5],
                        crc_calc_q[4] ^ inv, crc_calc_q[3:0], inv};
    assign rx_shift  = {crc_rx_q[14:0], bus.BITVAL};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            crc_calc_q <= '0;
            crc_rx_q   <= '0;
            crc_ok_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_calc_q <= crc_calc_d;
            crc_rx_q   <= crc_rx_d;
            crc_ok_q   <= crc_ok_d;
            done_q     <= done_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_calc_d = crc_calc_q;
        crc_rx_d   = crc_rx_q;
        crc_ok_d   = crc_ok_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    crc_calc_d = '0;
                    crc_rx_d   = '0;
                    crc_ok_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (abort) begin
                    crc_ok_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (bus.BIT_EN) begin
                    crc_calc_d = lfsr_next;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (abort) begin
                    crc_ok_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (bus.BIT_EN) begin
                    crc_rx_d = rx_shift;
                    cnt_d    = cnt_q + 1'b1;
                    // Compare against the shifted value, since the 16th bit is not yet in crc_rx_q.
                    if (cnt_q == LAST_CRC) begin
                        crc_ok_d = (rx_shift == crc_calc_q);
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY     = (state_q != S_IDLE);
        bus.DONE     = done_q;
        bus.CRC_OK   = crc_ok_q;
        bus.CRC_CALC = crc_calc_q;
        bus.CRC_RX   = crc_rx_q;
    end

endmodule

// File: tb/tb_sd_crc_16_chk.sv
// Directed bench for sd_crc_16_chk: a 4096-bit instance and a 72-bit instance ("123456789").
// Abort scenarios run only when SD_CRC16_CHK_ABORT_EN is defined.
module tb_sd_crc_16_chk;

    logic CLK = 1'b0;
    logic RST;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   done_ref;

    always #5 CLK = ~CLK;

    sd_crc_16_chk_if sb ();
    sd_crc_16_chk_if bb ();

    sd_crc_16_chk #(.BLOCK_BITS(72), .CNT_W(13)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (sb.slave)
    );

    sd_crc_16_chk #(.BLOCK_BITS(4096), .CNT_W(13)) dut_big (
        .CLK (CLK),
        .RST (RST),
        .bus (bb.slave)
    );

    // "123456789" followed by its CRC, and the same data with a corrupted CRC.
    localparam logic [87:0] VEC_GOOD = {72'h313233343536373839, 16'h31C3};
    localparam logic [87:0] VEC_BAD  = {72'h313233343536373839, 16'h31C2};
    localparam logic [87:0] VEC_ZERO = 88'h0;

    always @(negedge CLK) if (sb.DONE) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_small();
        sb.START = 1'b1;
        tick();
        sb.START = 1'b0;
    endtask

    // Sends v[87-lo] .. v[87-(hi-1)], each preceded by 0..gapmax idle cycles.
    task automatic send_bits(input logic [87:0] v, input int lo, input int hi, input int gapmax);
        for (int i = lo; i < hi; i++) begin
            int gap;
            gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            sb.BIT_EN = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            sb.BIT_EN = 1'b1;
            sb.BITVAL = v[87 - i];
            tick();
        end
        sb.BIT_EN = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] big_crc;
        big_crc   = 16'h7FA1;
        RST       = 1'b1;
        sb.START  = 1'b0; sb.BIT_EN = 1'b0; sb.BITVAL = 1'b0;
        bb.START  = 1'b0; bb.BIT_EN = 1'b0; bb.BITVAL = 1'b0;
`ifdef SD_CRC16_CHK_ABORT_EN
        sb.ABORT  = 1'b0;
        bb.ABORT  = 1'b0;
`endif
        tick(); tick();
        RST = 1'b0;
        tick();

        check("rst_busy",  32'(sb.BUSY),     32'd0);
        check("rst_done",  32'(sb.DONE),     32'd0);
        check("rst_ok",    32'(sb.CRC_OK),   32'd0);
        check("rst_calc",  32'(sb.CRC_CALC), 32'h0);
        check("rst_rx",    32'(sb.CRC_RX),   32'h0);

        // BIT_EN in IDLE must not touch the CRC.
        sb.BIT_EN = 1'b1; sb.BITVAL = 1'b1;
        tick();
        sb.BIT_EN = 1'b0;
        check("idle_bit_calc", 32'(sb.CRC_CALC), 32'h0);
        check("idle_bit_busy", 32'(sb.BUSY),     32'd0);

        // 4096 ones + 0x7FA1, continuous BIT_EN: DONE after exactly 4112 bit edges.
        bb.START = 1'b1;
        tick();
        bb.START = 1'b0;
        check("big_busy_rise", 32'(bb.BUSY), 32'd1);
        bb.BIT_EN = 1'b1;
        for (int i = 0; i < 4112; i++) begin
            bb.BITVAL = (i < 4096) ? 1'b1 : big_crc[15 - (i - 4096)];
            tick();
            if (i == 4110) begin
                check("big_done_early", 32'(bb.DONE), 32'd0);
                check("big_busy_late",  32'(bb.BUSY), 32'd1);
            end
        end
        bb.BIT_EN = 1'b0;
        check("big_done",  32'(bb.DONE),     32'd1);
        check("big_busy",  32'(bb.BUSY),     32'd0);
        check("big_ok",    32'(bb.CRC_OK),   32'd1);
        check("big_calc",  32'(bb.CRC_CALC), 32'h7FA1);
        check("big_rx",    32'(bb.CRC_RX),   32'h7FA1);
        tick();
        check("big_done_fall", 32'(bb.DONE),   32'd0);
        check("big_ok_hold",   32'(bb.CRC_OK), 32'd1);

        // "123456789" with random gaps; CRC of the lone byte '1' is 0x2672.
        start_small();
        check("b_busy", 32'(sb.BUSY), 32'd1);
        done_ref = done_cnt;
        send_bits(VEC_GOOD, 0, 8, 2);
        check("b_calc_byte1", 32'(sb.CRC_CALC), 32'h2672);
        send_bits(VEC_GOOD, 8, 88, 2);
        check("b_done", 32'(sb.DONE),     32'd1);
        check("b_ok",   32'(sb.CRC_OK),   32'd1);
        check("b_calc", 32'(sb.CRC_CALC), 32'h31C3);
        check("b_rx",   32'(sb.CRC_RX),   32'h31C3);
        tick(); tick(); tick();
        check("b_one_done", 32'(done_cnt - done_ref), 32'd1);
        check("b_busy_end", 32'(sb.BUSY), 32'd0);

        // Same data, wrong CRC.
        start_small();
        check("c_ok_cleared", 32'(sb.CRC_OK), 32'd0);
        send_bits(VEC_BAD, 0, 88, 1);
        check("c_done", 32'(sb.DONE),     32'd1);
        check("c_ok",   32'(sb.CRC_OK),   32'd0);
        check("c_rx",   32'(sb.CRC_RX),   32'h31C2);
        check("c_calc", 32'(sb.CRC_CALC), 32'h31C3);
        tick();

        // All-zero block, then START in the DONE cycle; START mid-block is ignored.
        start_small();
        send_bits(VEC_ZERO, 0, 88, 0);
        check("d_done", 32'(sb.DONE),   32'd1);
        check("d_ok",   32'(sb.CRC_OK), 32'd1);
        start_small();
        check("d_b2_done_fall", 32'(sb.DONE),   32'd0);
        check("d_b2_busy",      32'(sb.BUSY),   32'd1);
        check("d_b2_ok_clear",  32'(sb.CRC_OK), 32'd0);
        done_ref = done_cnt;
        send_bits(VEC_GOOD, 0, 40, 0);
        start_small();
        send_bits(VEC_GOOD, 40, 88, 0);
        check("d_b2_done", 32'(sb.DONE),     32'd1);
        check("d_b2_ok",   32'(sb.CRC_OK),   32'd1);
        check("d_b2_calc", 32'(sb.CRC_CALC), 32'h31C3);
        tick();
        check("d_b2_one_done", 32'(done_cnt - done_ref), 32'd1);

        // Reset halfway through the data: immediate clear, no DONE.
        start_small();
        send_bits(VEC_GOOD, 0, 36, 0);
        done_ref = done_cnt;
        #2 RST = 1'b1;
        #1;
        check("e_rst_busy", 32'(sb.BUSY),     32'd0);
        check("e_rst_done", 32'(sb.DONE),     32'd0);
        check("e_rst_ok",   32'(sb.CRC_OK),   32'd0);
        check("e_rst_calc", 32'(sb.CRC_CALC), 32'h0);
        check("e_rst_rx",   32'(sb.CRC_RX),   32'h0);
        tick();
        RST = 1'b0;
        send_bits(VEC_GOOD, 36, 88, 0);
        tick();
        check("e_no_done",   32'(done_cnt - done_ref), 32'd0);
        check("e_idle_calc", 32'(sb.CRC_CALC),         32'h0);
        start_small();
        send_bits(VEC_GOOD, 0, 88, 2);
        check("e_clean_done", 32'(sb.DONE),   32'd1);
        check("e_clean_ok",   32'(sb.CRC_OK), 32'd1);
        tick();

`ifdef SD_CRC16_CHK_ABORT_EN
        // ABORT while presenting CRC bit 5; only the first four CRC bits (0x3) were taken.
        start_small();
        done_ref = done_cnt;
        send_bits(VEC_GOOD, 0, 76, 0);
        sb.ABORT  = 1'b1;
        sb.BIT_EN = 1'b1;
        sb.BITVAL = VEC_GOOD[87 - 76];
        tick();
        sb.ABORT  = 1'b0;
        sb.BIT_EN = 1'b0;
        check("f_busy", 32'(sb.BUSY),     32'd0);
        check("f_done", 32'(sb.DONE),     32'd0);
        check("f_ok",   32'(sb.CRC_OK),   32'd0);
        check("f_calc", 32'(sb.CRC_CALC), 32'h31C3);
        check("f_rx",   32'(sb.CRC_RX),   32'h3);
        send_bits(VEC_GOOD, 77, 88, 0);
        tick();
        check("f_rx_hold", 32'(sb.CRC_RX),            32'h3);
        check("f_no_done", 32'(done_cnt - done_ref), 32'd0);
        sb.ABORT = 1'b1;
        start_small();
        sb.ABORT = 1'b0;
        check("f_start_wins", 32'(sb.BUSY), 32'd1);
        send_bits(VEC_GOOD, 0, 88, 0);
        check("f_after_ok", 32'(sb.CRC_OK), 32'd1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
